// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the serial carry-lookahead adder.
// Build option: ADDER_SUB_EN (adds the subtract mode to serial_cla_adder).
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Number of GROUP-bit slices needed to cover a WIDTH-bit operand.
  function automatic int ngroups(input int width, input int group);
    return width / group;
  endfunction

  // Width of the slice index register; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice, purely combinational.
// Every carry is a flat sum of generate/propagate products, so the slice
// depth does not grow with a ripple through its bits.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Expand c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin for every bit.
  always_comb begin
    logic any;
    logic term;
    // NOTE: every variable gets a value before any branch or loop so no
    // path leaves it unassigned and no latch is inferred.
    any  = 1'b0;
    term = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      any = cin;
      for (int j = 0; j <= i; j++) begin
        any = any & p[j];
      end
      for (int k = 0; k <= i; k++) begin
        term = g[k];
        for (int m = k + 1; m <= i; m++) begin
          term = term & p[m];
        end
        any = any | term;
      end
      c[i+1] = any;
    end
  end

  assign sum   = p ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/serial_cla_adder.sv
// Multi-cycle adder/subtractor: one GROUP-bit lookahead slice per clock,
// carry passed between slices through carry_reg, valid/ready on both sides.
// Build option: define ADDER_SUB_EN to add the sub port and a - b mode.
module serial_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGROUPS = ngroups(WIDTH, GROUP);
  localparam int IW      = idx_width(NGROUPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NGROUPS - 1);

  if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_cfg
    $error("serial_cla_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  logic [WIDTH-1:0] b_eff;
  logic             c0;

`ifdef ADDER_SUB_EN
  // a - b is a + ~b + 1; cin plays no part in subtract mode.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;
`else
  assign b_eff = b;
  assign c0    = cin;
`endif

  logic [GROUP-1:0] slice_a;
  logic [GROUP-1:0] slice_b;
  logic [GROUP-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;

  assign slice_a = a_reg[idx*GROUP +: GROUP];
  assign slice_b = b_reg[idx*GROUP +: GROUP];

  cla_group #(
    .GROUP (GROUP)
  ) u_group (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (carry_reg),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  assign out_valid = (state == DONE);

  // Control FSM, slice sequencing and result registers.
  // in_ready is a flop so it stays low in the cycle after a sampled reset.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      // NOTE: a_reg/b_reg are deliberately not reset: they are always
      // loaded at acceptance before being read, so a reset adds nothing.
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_reg     <= a;
            b_reg     <= b_eff;
            carry_reg <= c0;
            idx       <= '0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum[idx*GROUP +: GROUP] <= slice_sum;
          carry_reg               <= slice_cout;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            cout  <= slice_cout;
            ovf   <= slice_cmsb ^ slice_cout;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cla_adder.sv
// Directed bench for serial_cla_adder: a 32/4 instance and an 8/8 instance.
// Subtract vectors are included when ADDER_SUB_EN is defined.
module tb_serial_cla_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, cout, ovf;
`ifdef ADDER_SUB_EN
  logic        sub;
`endif

  logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8;
  logic [7:0]  a_8, b_8, sum_8;
  logic        cin_8, cout_8, ovf_8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_cla_adder #(.WIDTH(32), .GROUP(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  serial_cla_adder #(.WIDTH(8), .GROUP(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_8),
    .in_ready  (in_ready_8),
    .a         (a_8),
    .b         (b_8),
    .cin       (cin_8),
`ifdef ADDER_SUB_EN
    .sub       (1'b0),
`endif
    .out_valid (out_valid_8),
    .out_ready (out_ready_8),
    .sum       (sum_8),
    .cout      (cout_8),
    .ovf       (ovf_8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present operands on the 32-bit instance; returns #1 after the accept edge.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", in_ready, 1);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ready_after"}, in_ready, 1);
    check({tag, "_valid_after"}, out_valid, 0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic cv, input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    start_op(av, bv, cv);
    check({tag, "_busy"}, in_ready, 0);
    wait_done(lat);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    handshake(tag);
  endtask

  task automatic run_op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    check({tag, "_ready"}, in_ready_8, 1);
    a_8 = av; b_8 = bv; cin_8 = cv; in_valid_8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid_8 = 1'b0;
    check({tag, "_busy"}, in_ready_8, 0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, out_valid_8, 1);
    check({tag, "_sum"}, sum_8, es);
    check({tag, "_cout"}, cout_8, ec);
    check({tag, "_ovf"}, ovf_8, eo);
    @(negedge clk);
    out_ready_8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready_8 = 1'b0;
    check({tag, "_ready_after"}, in_ready_8, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid_8 = 1'b0; out_ready_8 = 1'b0; a_8 = '0; b_8 = '0; cin_8 = 1'b0;
`ifdef ADDER_SUB_EN
    sub = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sum8", sum_8, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_ready8", in_ready_8, 1);

    // Add mode vectors
    run_op("carry_all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("mixed",     32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
    run_op("neg_ovf",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

`ifdef ADDER_SUB_EN
    // Subtract: cin is driven high to show it is ignored
    sub = 1'b1;
    run_op("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    sub = 1'b0;
`endif

    // Backpressure: result held, new operands ignored while DONE
    start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    wait_done(lat);
    check("bp_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      check("bp_sum", sum, 32'hACF1_3568);
      check("bp_cout", cout, 0);
      check("bp_ovf", ovf, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("bp_no_accept_exit", in_ready, 1);
    check("bp_valid_dropped", out_valid, 0);

    // Reset in the middle of RUN with idx == 3
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    check("abort_ready_high", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_result", out_valid, 0);
    run_op("after_abort", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);

    // Single-slice instance
    run_op8("w8_carry", 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0);
    run_op8("w8_ovf",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
